// File: rtl/cache_mem_arbiter.sv
// Shares one main-memory port between the I-cache and D-cache miss paths: dirty write-back, refill read, watchdog abort.
// Define ARB_RR_EN to break simultaneous requests round-robin instead of fixed D-cache priority.
//
// state | meaning
// IDLE  | no transaction; arbitrate between ic_req and dc_req
// WB    | D-cache victim write-back in progress on the memory port
// RD    | refill read in progress on the memory port
// DONE  | one-cycle grant (and err on abort) to the owning cache
module cache_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_gnt,
  output logic [DATA_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic              dc_wb,
  input  logic [ADDR_W-1:0] dc_wb_addr,
  input  logic [DATA_W-1:0] dc_wb_data,
  output logic              dc_gnt,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WB   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;       // 1 = D-cache, 0 = I-cache
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              ic_gnt_q, ic_gnt_d;
  logic              dc_gnt_q, dc_gnt_d;
  logic [DATA_W-1:0] ic_rdata_q, ic_rdata_d;
  logic [DATA_W-1:0] dc_rdata_q, dc_rdata_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              dc_win;
  logic              fin;
  logic              fin_err;
  logic [DATA_W-1:0] fin_data;
  logic              wd_hit;

`ifdef ARB_RR_EN
  logic last_owner_q, last_owner_d;          // 1 = D-cache served last
  assign dc_win = dc_req && !(ic_req && last_owner_q);
`else
  assign dc_win = dc_req;
`endif

  assign wd_hit = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rd_addr_d   = rd_addr_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ic_gnt_d    = 1'b0;
    dc_gnt_d    = 1'b0;
    err_d       = 1'b0;
    ic_rdata_d  = ic_rdata_q;
    dc_rdata_d  = dc_rdata_q;
    fin         = 1'b0;
    fin_err     = 1'b0;
    fin_data    = '0;
`ifdef ARB_RR_EN
    last_owner_d = last_owner_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (dc_win) begin
          owner_d   = 1'b1;
          rd_addr_d = dc_addr;
          cnt_d     = '0;
          mem_req_d = 1'b1;
          if (dc_wb) begin
            state_d     = ST_WB;
            mem_we_d    = 1'b1;
            mem_addr_d  = dc_wb_addr;
            mem_wdata_d = dc_wb_data;
          end else begin
            state_d    = ST_RD;
            mem_we_d   = 1'b0;
            mem_addr_d = dc_addr;
          end
        end else if (ic_req) begin
          owner_d    = 1'b0;
          rd_addr_d  = ic_addr;
          cnt_d      = '0;
          state_d    = ST_RD;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = ic_addr;
        end
      end
      ST_WB: begin
        // Write-back handed straight to the refill read: mem_req stays high.
        if (mem_ready) begin
          state_d    = ST_RD;
          cnt_d      = '0;
          mem_we_d   = 1'b0;
          mem_addr_d = rd_addr_q;
        end else if (wd_hit) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RD: begin
        if (mem_ready) begin
          fin      = 1'b1;
          fin_data = mem_rdata;
        end else if (wd_hit) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fin) begin
      state_d   = ST_DONE;
      mem_req_d = 1'b0;
      mem_we_d  = 1'b0;
      err_d     = fin_err;
      if (owner_q) begin
        dc_gnt_d   = 1'b1;
        dc_rdata_d = fin_data;
      end else begin
        ic_gnt_d   = 1'b1;
        ic_rdata_d = fin_data;
      end
`ifdef ARB_RR_EN
      last_owner_d = owner_q;
`endif
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      rd_addr_q   <= '0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ic_gnt_q    <= 1'b0;
      dc_gnt_q    <= 1'b0;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rd_addr_q   <= rd_addr_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ic_gnt_q    <= ic_gnt_d;
      dc_gnt_q    <= dc_gnt_d;
      ic_rdata_q  <= ic_rdata_d;
      dc_rdata_q  <= dc_rdata_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_owner_q <= 1'b0;
    else        last_owner_q <= last_owner_d;
  end
`endif

  assign ic_gnt    = ic_gnt_q;
  assign dc_gnt    = dc_gnt_q;
  assign ic_rdata  = ic_rdata_q;
  assign dc_rdata  = dc_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: transaction-queue reference model checked every cycle, plus directed literal checks.
module tb_cache_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ic_req = 1'b0, dc_req = 1'b0, dc_wb = 1'b0;
  logic [AW-1:0] ic_addr = '0, dc_addr = '0, dc_wb_addr = '0;
  logic [DW-1:0] dc_wb_data = '0;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          ic_gnt, dc_gnt, mem_req, mem_we, busy, err;
  logic [DW-1:0] ic_rdata, dc_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_addr(dc_addr), .dc_wb(dc_wb), .dc_wb_addr(dc_wb_addr),
    .dc_wb_data(dc_wb_data), .dc_gnt(dc_gnt), .dc_rdata(dc_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a transaction is a queue of memory phases still to complete.
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } op_t;

  op_t           ops[$];
  op_t           cur;
  bit            m_done = 0, m_owner_d = 0, m_last_d = 0, take_d;
  int            m_wait = 0;
  logic          e_ic_gnt = 0, e_dc_gnt = 0, e_err = 0;
  logic [DW-1:0] e_ic_rdata = '0, e_dc_rdata = '0;

  task automatic m_grant(input logic [DW-1:0] d, input logic er);
    m_done = 1;
    e_err  = er;
    if (m_owner_d) begin e_dc_gnt = 1; e_dc_rdata = d; end
    else begin e_ic_gnt = 1; e_ic_rdata = d; end
    m_last_d = m_owner_d;
    ops.delete();
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops.delete();
      m_done = 0; m_wait = 0; m_owner_d = 0; m_last_d = 0;
      e_ic_gnt = 0; e_dc_gnt = 0; e_err = 0; e_ic_rdata = '0; e_dc_rdata = '0;
    end else begin
      e_ic_gnt = 0; e_dc_gnt = 0; e_err = 0;
      if (m_done) begin
        m_done = 0;
      end else if (ops.size() == 0) begin
        take_d = dc_req && !(RR && ic_req && m_last_d);
        if (take_d) begin
          m_owner_d = 1; m_wait = 0;
          if (dc_wb) ops.push_back(op_t'{1'b1, dc_wb_addr, dc_wb_data});
          ops.push_back(op_t'{1'b0, dc_addr, '0});
        end else if (ic_req) begin
          m_owner_d = 0; m_wait = 0;
          ops.push_back(op_t'{1'b0, ic_addr, '0});
        end
      end else if (mem_ready) begin
        cur = ops.pop_front();
        m_wait = 0;
        if (!cur.we) m_grant(mem_rdata, 1'b0);
      end else begin
        m_wait++;
        if (m_wait == TO) m_grant('0, 1'b1);
      end
    end
  end

  always @(negedge clk) begin
    check("busy", busy, (ops.size() != 0) || m_done);
    check("mem_req", mem_req, ops.size() != 0);
    if (ops.size() != 0) begin
      check("mem_we", mem_we, ops[0].we);
      check("mem_addr", mem_addr, ops[0].addr);
      if (ops[0].we) check("mem_wdata", mem_wdata, ops[0].wdata);
    end
    check("ic_gnt", ic_gnt, e_ic_gnt);
    check("dc_gnt", dc_gnt, e_dc_gnt);
    check("err", err, e_err);
    check("ic_rdata", ic_rdata, e_ic_rdata);
    check("dc_rdata", dc_rdata, e_dc_rdata);
  end

  // Memory responder: answers each phase after mem_delay idle request cycles.
  int            mem_delay = 0;
  int            wait_cnt = 0;
  bit            spurious = 0;
  logic [DW-1:0] rd_val = '0;
  op_t           log_q[$];

  always @(negedge clk) begin
    mem_ready = 1'b0;
    if (spurious) begin
      mem_ready = 1'b1;
    end else if (mem_req === 1'b1) begin
      if (wait_cnt == mem_delay) begin
        mem_ready = 1'b1;
        mem_rdata = rd_val;
        log_q.push_back(op_t'{mem_we, mem_addr, mem_wdata});
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic wait_gnt(output int who, output int cyc);
    who = -1; cyc = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (dc_gnt === 1'b1) begin who = 1; cyc = i; break; end
      if (ic_gnt === 1'b1) begin who = 0; cyc = i; break; end
    end
    if (who < 0) begin
      n_checks++; n_errors++;
      $display("FAIL wait_gnt: no grant within 200 cycles (t=%0t)", $time);
    end
  endtask

  int who, cyc, base, g1, g2, g3, gcount;

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_gnts", {ic_gnt, dc_gnt, err}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean D-miss, memory answers after 2 wait cycles
    base = log_q.size();
    mem_delay = 2; rd_val = 32'hDEADBEEF;
    dc_req = 1; dc_wb = 0; dc_addr = 32'h100;
    wait_gnt(who, cyc);
    dc_req = 0;
    check("clean_who", who, 1);
    check("clean_cyc", cyc, 4);
    check("clean_rdata", dc_rdata, 32'hDEADBEEF);
    check("clean_ic_gnt", ic_gnt, 0);
    check("clean_nops", log_q.size() - base, 1);
    check("clean_addr", log_q[base].addr, 32'h100);
    check("clean_we", log_q[base].we, 0);
    repeat (2) @(negedge clk);

    // Dirty D-miss, immediate memory answers
    base = log_q.size();
    mem_delay = 0; rd_val = 32'hCAFEF00D;
    dc_req = 1; dc_wb = 1; dc_wb_addr = 32'h200; dc_wb_data = 32'h12345678; dc_addr = 32'h300;
    wait_gnt(who, cyc);
    dc_req = 0; dc_wb = 0;
    check("dirty_who", who, 1);
    check("dirty_cyc", cyc, 3);
    check("dirty_rdata", dc_rdata, 32'hCAFEF00D);
    check("dirty_nops", log_q.size() - base, 2);
    check("dirty_wb", {log_q[base].we, log_q[base].addr, log_q[base].wdata}, {1'b1, 32'h200, 32'h12345678});
    check("dirty_rd", {log_q[base+1].we, log_q[base+1].addr}, {1'b0, 32'h300});
    repeat (2) @(negedge clk);

    // Clean I-miss latency
    rd_val = 32'h0000_1CE0;
    ic_req = 1; ic_addr = 32'h40;
    wait_gnt(who, cyc);
    ic_req = 0;
    check("imiss_who", who, 0);
    check("imiss_cyc", cyc, 2);
    check("imiss_rdata", ic_rdata, 32'h0000_1CE0);
    repeat (2) @(negedge clk);

    // Tie, then D re-requests at once so a second tie follows
    rd_val = 32'h11112222;
    ic_req = 1; ic_addr = 32'h40; dc_req = 1; dc_addr = 32'h500;
    wait_gnt(g1, cyc);
    dc_addr = 32'h600;
    wait_gnt(g2, cyc);
    if (g2 == 1) dc_req = 0; else ic_req = 0;
    wait_gnt(g3, cyc);
    ic_req = 0; dc_req = 0;
    check("tie_first", g1, 1);
    check("tie_second", g2, RR ? 0 : 1);
    check("tie_third", g3, RR ? 1 : 0);
    repeat (2) @(negedge clk);

    // Spurious mem_ready while idle
    spurious = 1;
    repeat (2) @(negedge clk);
    spurious = 0;
    check("spurious_busy", busy, 0);
    @(negedge clk);

    // Read timeout
    mem_delay = 1000;
    ic_req = 1; ic_addr = 32'h40;
    wait_gnt(who, cyc);
    ic_req = 0;
    check("to_who", who, 0);
    check("to_cyc", cyc, 5);
    check("to_err", err, 1);
    check("to_rdata", ic_rdata, 0);
    @(negedge clk);
    check("to_busy_after", busy, 0);
    @(negedge clk);

    // Write-back timeout: no read follows
    base = log_q.size();
    dc_req = 1; dc_wb = 1; dc_wb_addr = 32'h700; dc_wb_data = 32'hA5A5A5A5; dc_addr = 32'h800;
    wait_gnt(who, cyc);
    dc_req = 0; dc_wb = 0;
    check("wbto_who", who, 1);
    check("wbto_cyc", cyc, 5);
    check("wbto_err", err, 1);
    check("wbto_rdata", dc_rdata, 0);
    check("wbto_nops", log_q.size() - base, 0);
    repeat (2) @(negedge clk);

    // Reset in the middle of a write-back
    dc_req = 1; dc_wb = 1; dc_wb_addr = 32'h900; dc_wb_data = 32'h5A5A5A5A; dc_addr = 32'hA00;
    @(negedge clk);
    check("mid_wb_req", {mem_req, mem_we}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mem_req", mem_req, 0);
    check("arst_busy", busy, 0);
    check("arst_gnts", {ic_gnt, dc_gnt}, 0);
    dc_req = 0; dc_wb = 0;
    @(negedge clk);
    rst_n = 1'b1;
    gcount = 0;
    repeat (6) begin
      @(negedge clk);
      if (ic_gnt === 1'b1 || dc_gnt === 1'b1) gcount++;
    end
    check("post_rst_no_gnt", gcount, 0);
    check("post_rst_idle", busy, 0);

    // Normal I-miss after reset
    mem_delay = 3; rd_val = 32'h0BADF00D;
    ic_req = 1; ic_addr = 32'h80;
    wait_gnt(who, cyc);
    ic_req = 0;
    check("final_who", who, 0);
    check("final_cyc", cyc, 5);
    check("final_rdata", ic_rdata, 32'h0BADF00D);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sequences and shares the single main-memory port between the instruction-cache and data-cache miss paths of the RISC-V core.
- For a D-cache miss with a dirty victim: issues the write-back first, then the refill read.
- Returns refill data and a one-cycle grant to the owning cache.
- A watchdog aborts transactions the memory never acknowledges.

Parameters:
- ADDR_W, 32, address width of all address ports
- DATA_W, 32, data width of all data ports
- TIMEOUT, 64, cycles a memory phase may wait for mem_ready before abort; legal range 2..255

Ports:
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- ic_req  in  1  I-cache miss request, level, held until ic_gnt
- ic_addr  in  ADDR_W  I-cache refill address
- ic_gnt  out  1  one-cycle pulse: I-cache transaction complete
- ic_rdata  out  DATA_W  refill data, valid with ic_gnt
- dc_req  in  1  D-cache miss request, level, held until dc_gnt
- dc_addr  in  ADDR_W  D-cache refill address
- dc_wb  in  1  victim dirty, write-back required (sampled with dc_req)
- dc_wb_addr  in  ADDR_W  victim address
- dc_wb_data  in  DATA_W  victim data
- dc_gnt  out  1  one-cycle pulse: D-cache transaction complete
- dc_rdata  out  DATA_W  refill data, valid with dc_gnt
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ready  in  1  memory completes current phase this cycle
- mem_rdata  in  DATA_W  read data, valid with mem_ready on a read
- busy  out  1  state != IDLE
- err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs 0; timeout counter 0; owner 0; last_owner = I-cache. A transaction in flight is abandoned; no grant is issued for it.
- States: IDLE, WB, RD, DONE. All outputs are registered.
- IDLE, arbitration:
  - If dc_req: owner = D; latch dc_addr, dc_wb, dc_wb_addr, dc_wb_data. Next state is WB if dc_wb, else RD.
  - Else if ic_req: owner = I; latch ic_addr; next state RD.
  - Both requests: D-cache wins (fixed priority; see Optional Feature).
- WB: mem_req=1, mem_we=1, mem_addr/mem_wdata = latched victim. On mem_ready go to RD; mem_req stays 1 with no bubble, mem_we drops to 0.
- RD: mem_req=1, mem_we=0, mem_addr = latched refill address. On mem_ready capture mem_rdata into the owner's rdata register and go to DONE.
- DONE:
  - mem_req=0; owner's gnt=1 for exactly this cycle; rdata held.
  - req inputs are ignored in DONE. Next state IDLE.
  - The requester must drop req the cycle after gnt; a req still high in IDLE is treated as a new miss.
- mem_req, mem_we, mem_addr and mem_wdata are stable from assertion until the mem_ready cycle.
- Latency: req seen in IDLE at edge N; mem_req high from N+1. With mem_ready in the first request cycle, gnt is at N+2 (clean) or N+3 (dirty).
- Watchdog:
  - Counter clears on entry to WB and to RD, and increments each WB/RD cycle without mem_ready.
  - On reaching TIMEOUT: go to DONE with err=1; owner's gnt=1; owner's rdata=0; mem_req drops.
  - mem_ready in the same cycle as the limit wins (normal completion, no err).
- mem_ready seen in IDLE or DONE is ignored.
- Non-owner gnt is 0 at all times; non-owner rdata holds its last value.

Optional Feature:
- ARB_RR_EN defined: round-robin on simultaneous requests.
  - A 1-bit last_owner register updates on each grant; when both requests are present, the requester not served last wins.
  - With last_owner reset to I-cache, the first tie goes to the D-cache.
- ARB_RR_EN undefined: fixed D-cache priority; last_owner is not implemented.

Test Plan:
- Clean D-miss: dc_req=1, dc_wb=0, dc_addr=0x100, mem_ready after 2 cycles with mem_rdata=0xDEADBEEF -> single read to 0x100; dc_gnt one pulse; dc_rdata=0xDEADBEEF; ic_gnt=0.
- Dirty D-miss: dc_wb=1, dc_wb_addr=0x200, dc_wb_data=0x12345678, dc_addr=0x300 -> write 0x12345678 @0x200 (mem_we=1), then read @0x300 with no mem_req gap; then dc_gnt.
- Tie: ic_req and dc_req high together, each held until its gnt -> D served first, then I. With ARB_RR_EN and a repeated tie, the second tie goes to I.
- Timeout, TIMEOUT=4: ic_req at 0x40, mem_ready never -> after 4 RD cycles err=1 and ic_gnt=1 in the same cycle; ic_rdata=0; busy low the next cycle.
- Reset mid-WB: rst_n low while mem_req=1, mem_we=1 -> mem_req, busy and all gnts go 0 immediately (async). After release, state is IDLE and no gnt is issued for the abandoned transaction.
